// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mux_2to1_16.sv
// 16-bit 2:1 mux selecting the memory address source.
module mux_2to1_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_sel,
  output logic [15:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data stage,
// sequencing each access over a fixed MEM_LAT-cycle latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          addr_sel,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned    CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sel;
  logic            r_if_ack;
  logic            r_d_ack;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_d_rdata;
  logic            w_busy;

  // Acks are set on the BUSY->DONE edge so they are high for exactly the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel      <= OWN_IF;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (d_req) begin
            r_sel   <= OWN_D;
            r_cnt   <= CNT_INIT;
            r_state <= BUSY;
          end else if (if_req) begin
            r_sel   <= OWN_IF;
            r_cnt   <= CNT_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
            if (r_sel == OWN_D) begin
              r_d_ack <= 1'b1;
              if (!d_wr) r_d_rdata <= mem_rdata;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy    = (r_state == BUSY);

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_stall  = if_req & ~r_if_ack;
  assign d_stall   = d_req & ~r_d_ack;
  assign addr_sel  = r_sel;
  assign mem_en    = w_busy;
  assign mem_wr    = w_busy & (r_sel == OWN_D) & d_wr;
  assign mem_wdata = d_wdata;

  mux_2to1_16 u_addr_mux (
    .i_a  (if_addr),
    .i_b  (d_addr),
    .i_sel(r_sel),
    .o_y  (mem_addr)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-timing model.
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_ack, if_stall, d_ack, d_stall, addr_sel, mem_en, mem_wr;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        l_rst = 1'b1, l_d_req = 1'b0, l_d_wr = 1'b0;
  logic [15:0] l_d_addr = '0, l_mem_rdata = '0;
  logic        l_if_ack, l_if_stall, l_d_ack, l_d_stall, l_addr_sel, l_mem_en, l_mem_wr;
  logic [15:0] l_if_rdata, l_d_rdata, l_mem_addr, l_mem_wdata;

  mem_port_arbiter #(.DW(16), .AW(16), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .addr_sel(addr_sel), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DW(16), .AW(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(l_rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_ack(l_if_ack), .if_rdata(l_if_rdata), .if_stall(l_if_stall),
    .d_req(l_d_req), .d_wr(l_d_wr), .d_addr(l_d_addr), .d_wdata(16'h0000),
    .d_ack(l_d_ack), .d_rdata(l_d_rdata), .d_stall(l_d_stall),
    .addr_sel(l_addr_sel), .mem_en(l_mem_en), .mem_wr(l_mem_wr),
    .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata), .mem_rdata(l_mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one transaction in flight, described by its grant cycle.
  logic [15:0] mem [logic [15:0]];
  int          cyc = 0, m_t = 0, m_free = 0;
  bit          m_act = 0, m_own = 0, m_wr = 0;
  logic [15:0] m_addr = '0, m_wdata = '0;
  logic        m_sel = 1'b0;
  logic [15:0] m_if_rd = '0, m_d_rd = '0;
  bit          e_busy, e_if_ack, e_d_ack;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5C3;
  endfunction

  task automatic settle();
    @(negedge clk);
    if (!m_act && cyc >= m_free && (d_req || if_req)) begin
      m_act   = 1;
      m_own   = d_req;
      m_t     = cyc;
      m_wr    = d_req && d_wr;
      m_addr  = d_req ? d_addr : if_addr;
      m_wdata = d_wdata;
    end
    e_busy   = m_act && cyc > m_t && cyc <= m_t + LAT;
    e_if_ack = m_act && cyc == m_t + LAT + 1 && !m_own;
    e_d_ack  = m_act && cyc == m_t + LAT + 1 && m_own;
    mem_rdata = (e_busy && cyc == m_t + LAT && !m_wr) ? mem_rd(m_addr) : 16'($urandom);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_free = cyc + 1; m_sel = 1'b0; m_if_rd = '0; m_d_rd = '0;
    end else if (m_act) begin
      if (cyc == m_t) m_sel = m_own;
      if (cyc == m_t + LAT) begin
        if (m_wr)       mem[m_addr] = m_wdata;
        else if (m_own) m_d_rd = mem_rdata;
        else            m_if_rd = mem_rdata;
      end
      if (cyc == m_t + LAT + 1) begin m_act = 0; m_free = cyc + 1; end
    end
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    advance();
    advance();
    rst = 1'b0;
    settle();
    checks++; if ({if_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b exp 00", {if_ack, d_ack}); end
    checks++; if ({mem_en, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_mem got %b exp 00", {mem_en, mem_wr}); end
    checks++; if (addr_sel !== 1'b0) begin errors++; $display("FAIL reset_addr_sel got %b exp 0", addr_sel); end
    checks++; if ({if_rdata, d_rdata} !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, d_rdata}); end
    advance();
  endtask

  task automatic test_fetch();
    mem[16'h0040] = 16'hBEEF;
    for (int k = 0; k <= 6; k++) begin
      if_req = (k <= 5); if_addr = 16'h0040;
      settle();
      checks++; if (mem_en !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL fetch_mem_en k=%0d got %b", k, mem_en); end
      checks++; if (if_ack !== (k == 5)) begin errors++; $display("FAIL fetch_if_ack k=%0d got %b", k, if_ack); end
      checks++; if (if_stall !== (k <= 4)) begin errors++; $display("FAIL fetch_if_stall k=%0d got %b", k, if_stall); end
      if (k >= 1 && k <= 4) begin
        checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL fetch_mem_addr k=%0d got %h exp 0040", k, mem_addr); end
      end
      if (k == 6) begin
        checks++; if (if_rdata !== 16'hBEEF) begin errors++; $display("FAIL fetch_if_rdata got %h exp beef", if_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_priority();
    mem[16'h1000] = 16'h00AA;
    mem[16'h0080] = 16'h3333;
    for (int k = 0; k <= 12; k++) begin
      d_req = (k <= 5); d_wr = 1'b0; d_addr = 16'h1000;
      if_req = (k <= 11); if_addr = 16'h0080;
      settle();
      checks++; if (d_ack !== (k == 5)) begin errors++; $display("FAIL prio_d_ack k=%0d got %b", k, d_ack); end
      checks++; if (if_ack !== (k == 11)) begin errors++; $display("FAIL prio_if_ack k=%0d got %b", k, if_ack); end
      checks++; if (mem_en !== ((k >= 1 && k <= 4) || (k >= 7 && k <= 10))) begin errors++; $display("FAIL prio_mem_en k=%0d got %b", k, mem_en); end
      checks++; if (d_stall !== (k <= 4)) begin errors++; $display("FAIL prio_d_stall k=%0d got %b", k, d_stall); end
      if (k >= 1 && k <= 5) begin
        checks++; if (addr_sel !== 1'b1) begin errors++; $display("FAIL prio_sel_d k=%0d got %b exp 1", k, addr_sel); end
      end
      if (k >= 7 && k <= 11) begin
        checks++; if (addr_sel !== 1'b0) begin errors++; $display("FAIL prio_sel_if k=%0d got %b exp 0", k, addr_sel); end
      end
      if (k == 6) begin
        checks++; if (d_rdata !== 16'h00AA) begin errors++; $display("FAIL prio_d_rdata got %h exp 00aa", d_rdata); end
      end
      if (k == 12) begin
        checks++; if (if_rdata !== 16'h3333) begin errors++; $display("FAIL prio_if_rdata got %h exp 3333", if_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_store();
    for (int k = 0; k <= 6; k++) begin
      d_req = (k <= 5); d_wr = 1'b1; d_addr = 16'h2000; d_wdata = 16'h1234;
      settle();
      checks++; if (mem_wr !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL store_mem_wr k=%0d got %b", k, mem_wr); end
      checks++; if (d_ack !== (k == 5)) begin errors++; $display("FAIL store_d_ack k=%0d got %b", k, d_ack); end
      checks++; if (d_rdata !== 16'h00AA) begin errors++; $display("FAIL store_d_rdata k=%0d got %h exp 00aa", k, d_rdata); end
      if (k >= 1 && k <= 4) begin
        checks++; if ({mem_addr, mem_wdata} !== 32'h2000_1234) begin errors++; $display("FAIL store_bus k=%0d got %h exp 20001234", k, {mem_addr, mem_wdata}); end
      end
      advance();
    end
    d_wr = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 10; k++) begin
      if_req = (k <= 9); if_addr = 16'h0100;
      rst = (k == 2 || k == 3);
      settle();
      checks++; if (mem_en !== ((k >= 1 && k <= 2) || (k >= 5 && k <= 8))) begin errors++; $display("FAIL rstmid_mem_en k=%0d got %b", k, mem_en); end
      checks++; if (if_ack !== (k == 9)) begin errors++; $display("FAIL rstmid_if_ack k=%0d got %b", k, if_ack); end
      if (k == 4) begin
        checks++; if ({addr_sel, if_rdata, d_rdata} !== 33'h0) begin errors++; $display("FAIL rstmid_regs got %h exp 0", {addr_sel, if_rdata, d_rdata}); end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    for (int k = 0; k <= 12; k++) begin
      if_req = (k <= 11); if_addr = 16'h0200;
      settle();
      if (if_ack === 1'b1) acks++;
      checks++; if (if_ack !== (k == 5 || k == 11)) begin errors++; $display("FAIL b2b_if_ack k=%0d got %b", k, if_ack); end
      checks++; if (mem_en !== ((k >= 1 && k <= 4) || (k >= 7 && k <= 10))) begin errors++; $display("FAIL b2b_mem_en k=%0d got %b", k, mem_en); end
      advance();
    end
    checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count got %0d exp 2", acks); end
  endtask

  task automatic test_lat1();
    advance();
    l_rst = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      l_d_req = (k <= 2); l_d_wr = 1'b0; l_d_addr = 16'h0300;
      settle();
      l_mem_rdata = (k == 1) ? 16'h5A5A : 16'h0F0F;
      #1;
      checks++; if (l_mem_en !== (k == 1)) begin errors++; $display("FAIL lat1_mem_en k=%0d got %b", k, l_mem_en); end
      checks++; if (l_d_ack !== (k == 2)) begin errors++; $display("FAIL lat1_d_ack k=%0d got %b", k, l_d_ack); end
      if (k == 1) begin
        checks++; if (l_mem_addr !== 16'h0300) begin errors++; $display("FAIL lat1_mem_addr got %h exp 0300", l_mem_addr); end
      end
      if (k == 3) begin
        checks++; if (l_d_rdata !== 16'h5A5A) begin errors++; $display("FAIL lat1_d_rdata got %h exp 5a5a", l_d_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    bit p_if_ack = 0, p_d_ack = 0;
    for (int i = 0; i < 400; i++) begin
      if (if_req && p_if_ack) if_req = 1'($urandom_range(0, 1));
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = {12'h300, 4'($urandom)};
      end
      if (d_req && p_d_ack) d_req = 1'($urandom_range(0, 1));
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_wr = 1'($urandom); d_addr = {12'h300, 4'($urandom)}; d_wdata = 16'($urandom);
      end
      rst = ($urandom_range(0, 59) == 0);
      settle();
      checks++; if (if_ack !== e_if_ack) begin errors++; $display("FAIL rnd_if_ack cyc=%0d got %b exp %b", cyc, if_ack, e_if_ack); end
      checks++; if (d_ack !== e_d_ack) begin errors++; $display("FAIL rnd_d_ack cyc=%0d got %b exp %b", cyc, d_ack, e_d_ack); end
      checks++; if (if_stall !== (if_req && !e_if_ack)) begin errors++; $display("FAIL rnd_if_stall cyc=%0d got %b", cyc, if_stall); end
      checks++; if (d_stall !== (d_req && !e_d_ack)) begin errors++; $display("FAIL rnd_d_stall cyc=%0d got %b", cyc, d_stall); end
      checks++; if (mem_en !== e_busy) begin errors++; $display("FAIL rnd_mem_en cyc=%0d got %b exp %b", cyc, mem_en, e_busy); end
      checks++; if (mem_wr !== (e_busy && m_own && d_wr)) begin errors++; $display("FAIL rnd_mem_wr cyc=%0d got %b", cyc, mem_wr); end
      checks++; if (addr_sel !== m_sel) begin errors++; $display("FAIL rnd_addr_sel cyc=%0d got %b exp %b", cyc, addr_sel, m_sel); end
      checks++; if (mem_addr !== (m_sel ? d_addr : if_addr)) begin errors++; $display("FAIL rnd_mem_addr cyc=%0d got %h", cyc, mem_addr); end
      checks++; if (mem_wdata !== d_wdata) begin errors++; $display("FAIL rnd_mem_wdata cyc=%0d got %h exp %h", cyc, mem_wdata, d_wdata); end
      checks++; if (if_rdata !== m_if_rd) begin errors++; $display("FAIL rnd_if_rdata cyc=%0d got %h exp %h", cyc, if_rdata, m_if_rd); end
      checks++; if (d_rdata !== m_d_rd) begin errors++; $display("FAIL rnd_d_rdata cyc=%0d got %h exp %h", cyc, d_rdata, m_d_rd); end
      p_if_ack = e_if_ack;
      p_d_ack  = e_d_ack;
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_reset_mid();
    test_back_to_back();
    test_lat1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
